// File: rtl/pipe_if_if.sv
// IF-side bus bundle: instruction memory req/ack plus the IF->ID buffer head.
// master = fetch stage, slave = memory model / decode stage.
interface pipe_if_if #(
  parameter int REG_SZ = 32
) ();
  logic              mem_req;
  logic [REG_SZ-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_data;
  logic              buf_avail;
  logic              buf_re;
  logic [31:0]       inst;
  logic [REG_SZ-1:0] pc_out;
  logic              pred_taken;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data,
    output buf_avail,
    input  buf_re,
    output inst,
    output pc_out,
    output pred_taken
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data,
    input  buf_avail,
    output buf_re,
    input  inst,
    input  pc_out,
    input  pred_taken
  );
endinterface

// File: rtl/pipe_if.sv
// Fetch stage: PC, one-outstanding word fetch, {pc,inst} FIFO toward ID.
// Define IF_BTFN_EN for static JAL / backward-branch prediction.
module pipe_if #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2,
  parameter int          REG_SZ     = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_if_if.master         bus,
  input  logic              redir_e,
  input  logic [REG_SZ-1:0] redir_pc,
  input  logic              stall
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state;
  logic [REG_SZ-1:0] pc;
  logic [REG_SZ-1:0] rpc;
  logic [REG_SZ-1:0] tgt;
  logic              pred;

  logic [REG_SZ-1:0] fifo_pc   [FIFO_DEPTH];
  logic [31:0]       fifo_inst [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nx;
  logic              avail;

  logic push;
  logic pop;
  logic flush;
  logic room;

  assign rpc   = redir_pc & ~(REG_SZ'(3));
  assign flush = redir_e;
  assign push  = (state == WAIT) && bus.mem_ack && !redir_e;
  assign pop   = bus.buf_re && avail;
  assign room  = count < CW'(FIFO_DEPTH);

`ifdef IF_BTFN_EN
  logic [REG_SZ-1:0] imm_j;
  logic [REG_SZ-1:0] imm_b;
  logic              is_jal;
  logic              is_bb;
  logic              fifo_pred [FIFO_DEPTH];

  assign imm_j = {{(REG_SZ-20){bus.mem_data[31]}},
                  bus.mem_data[19:12],
                  bus.mem_data[20],
                  bus.mem_data[30:21],
                  1'b0};
  assign imm_b = {{(REG_SZ-12){bus.mem_data[31]}},
                  bus.mem_data[7],
                  bus.mem_data[30:25],
                  bus.mem_data[11:8],
                  1'b0};
  assign is_jal = bus.mem_data[6:0] == 7'b1101111;
  assign is_bb  = (bus.mem_data[6:0] == 7'b1100011)
               && bus.mem_data[31];

  // Static predict on the word being pushed: JAL and backward branches taken.
  always_comb begin
    tgt  = pc + REG_SZ'(4);
    pred = 1'b0;
    unique case (1'b1)
      is_jal: begin
        tgt  = pc + imm_j;
        pred = 1'b1;
      end
      is_bb: begin
        tgt  = pc + imm_b;
        pred = 1'b1;
      end
      default: ;
    endcase
  end

  // Predicted-taken flag kept alongside each buffered entry.
  always_ff @(posedge clk) begin
    if (push) fifo_pred[wr_ptr] <= pred;
  end

  assign bus.pred_taken = avail ? fifo_pred[rd_ptr] : 1'b0;
`else
  assign tgt            = pc + REG_SZ'(4);
  assign pred           = 1'b0;
  assign bus.pred_taken = 1'b0;
`endif

  // Fetch sequencer: issue, wait for ack, drop stale data after redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= REG_SZ'(RESET_PC);
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (redir_e) begin
            pc <= rpc;
          end else if (!stall && room) begin
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= pc;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            state       <= IDLE;
            pc          <= redir_e ? rpc : tgt;
          end else if (redir_e) begin
            pc    <= rpc;
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (redir_e) pc <= rpc;
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          bus.mem_req <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Occupancy after this cycle's push/pop; flush empties outright.
  always_comb begin
    count_nx = count + CW'(push) - CW'(pop);
    if (flush) count_nx = '0;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      avail  <= 1'b0;
    end else begin
      count <= count_nx;
      avail <= count_nx != '0;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Entry storage; only the pointers need reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= pc;
      fifo_inst[wr_ptr] <= bus.mem_data;
    end
  end

  assign bus.buf_avail = avail;
  assign bus.inst      = avail ? fifo_inst[rd_ptr] : NOP;
  assign bus.pc_out    = avail ? fifo_pc[rd_ptr] : '0;

endmodule

// File: tb/tb_pipe_if.sv
// Directed bench for pipe_if: memory responder with programmable ack delay.
// Build with +define+IF_BTFN_EN to check the predicting variant.
module tb_pipe_if;

  logic        clk;
  logic        rst;
  logic        redir_e;
  logic [31:0] redir_pc;
  logic        stall;
  int          dly;
  int          wcnt;
  int          checks;
  int          errors;
  logic [31:0] fetched [$];

  pipe_if_if #(.REG_SZ(32)) bus ();

  pipe_if #(
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (2),
    .REG_SZ     (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master),
    .redir_e  (redir_e),
    .redir_pc (redir_pc),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h20) return 32'hFE000EE3;
    return {a[24:0], 7'b0010011};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Memory model: acks after dly idle cycles, logs every acked address.
  initial begin
    bus.mem_ack  = 1'b0;
    bus.mem_data = '0;
    wcnt         = 0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (rst) begin
        wcnt = 0;
      end else if (bus.mem_req) begin
        if (wcnt >= dly) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = word(bus.mem_addr);
          fetched.push_back(bus.mem_addr);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_addr(input logic [31:0] a, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_addr == a) begin
        hit = 1'b1;
        break;
      end
    end
    chk(tag, {63'd0, hit}, 64'd1);
  endtask

  task automatic redirect(input logic [31:0] a, input bit hold);
    bit idle;
    idle  = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.mem_req) begin
        idle = 1'b1;
        break;
      end
    end
    chk("redir_idle", {63'd0, idle}, 64'd1);
    redir_e  = 1'b1;
    redir_pc = a;
    @(negedge clk);
    redir_e = 1'b0;
    stall   = hold;
  endtask

  task automatic pop1();
    bus.buf_re = 1'b1;
    @(negedge clk);
    bus.buf_re = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    redir_e    = 1'b0;
    redir_pc   = '0;
    stall      = 1'b0;
    dly        = 0;
    bus.buf_re = 1'b0;
    cyc(3);
    chk("rst_req",   {63'd0, bus.mem_req}, 64'd0);
    chk("rst_addr",  {32'd0, bus.mem_addr}, 64'd0);
    chk("rst_avail", {63'd0, bus.buf_avail}, 64'd0);
    chk("rst_inst",  {32'd0, bus.inst}, 64'h13);
    chk("rst_pc",    {32'd0, bus.pc_out}, 64'd0);
    chk("rst_pred",  {63'd0, bus.pred_taken}, 64'd0);

    rst = 1'b0;
    cyc(10);
    chk("run_n",     64'(fetched.size()), 64'd2);
    chk("run_f0",    {32'd0, fetched[0]}, 64'h0);
    chk("run_f1",    {32'd0, fetched[1]}, 64'h4);
    chk("full_req",  {63'd0, bus.mem_req}, 64'd0);
    chk("full_pc",   {32'd0, bus.pc_out}, 64'h0);
    chk("full_inst", {32'd0, bus.inst}, {32'd0, word(32'h0)});
    pop1();
    chk("pop_pc",    {32'd0, bus.pc_out}, 64'h4);
    cyc(6);
    chk("pop_n",     64'(fetched.size()), 64'd3);
    chk("pop_f2",    {32'd0, fetched[2]}, 64'h8);

    dly = 3;
    pop1();
    wait_addr(32'hC, "wait_c");
    redir_e  = 1'b1;
    redir_pc = 32'h100;
    @(negedge clk);
    redir_e = 1'b0;
    fetched.delete();
    chk("fl_req",    {63'd0, bus.mem_req}, 64'd1);
    chk("fl_addr",   {32'd0, bus.mem_addr}, 64'hC);
    chk("fl_avail",  {63'd0, bus.buf_avail}, 64'd0);
    chk("fl_inst",   {32'd0, bus.inst}, 64'h13);
    cyc(14);
    chk("fl_stale",  {32'd0, fetched[0]}, 64'hC);
    chk("fl_new",    {32'd0, fetched[1]}, 64'h100);
    chk("fl_pc",     {32'd0, bus.pc_out}, 64'h100);
    chk("fl_word",   {32'd0, bus.inst}, {32'd0, word(32'h100)});

    dly = 0;
    redirect(32'h200, 1'b0);
    wait_addr(32'h200, "wait_200");
    redir_e  = 1'b1;
    redir_pc = 32'h40;
    @(negedge clk);
    redir_e = 1'b0;
    fetched.delete();
    chk("ackr_avail", {63'd0, bus.buf_avail}, 64'd0);
    cyc(8);
    chk("ackr_f0",   {32'd0, fetched[0]}, 64'h40);
    chk("ackr_pc",   {32'd0, bus.pc_out}, 64'h40);

    bus.buf_re = 1'b1;
    redir_e    = 1'b1;
    redir_pc   = 32'h80;
    @(negedge clk);
    bus.buf_re = 1'b0;
    redir_e    = 1'b0;
    chk("popr_avail", {63'd0, bus.buf_avail}, 64'd0);
    chk("popr_inst", {32'd0, bus.inst}, 64'h13);

    dly = 3;
    wait_addr(32'h80, "wait_80");
    stall = 1'b1;
    fetched.delete();
    cyc(12);
    chk("st_n",      64'(fetched.size()), 64'd1);
    chk("st_avail",  {63'd0, bus.buf_avail}, 64'd1);
    chk("st_pc",     {32'd0, bus.pc_out}, 64'h80);
    chk("st_req",    {63'd0, bus.mem_req}, 64'd0);
    stall = 1'b0;
    cyc(12);
    chk("st_n2",     64'(fetched.size()), 64'd2);
    chk("st_f1",     {32'd0, fetched[1]}, 64'h84);

    dly = 0;
    redirect(32'h500, 1'b1);
    pop1();
    chk("emp_avail", {63'd0, bus.buf_avail}, 64'd0);
    chk("emp_inst",  {32'd0, bus.inst}, 64'h13);
    chk("emp_pc",    {32'd0, bus.pc_out}, 64'd0);
    chk("emp_req",   {63'd0, bus.mem_req}, 64'd0);
    fetched.delete();
    stall = 1'b0;
    cyc(4);
    chk("emp_f0",    {32'd0, fetched[0]}, 64'h500);

    redirect(32'hFFFFFFFC, 1'b0);
    fetched.delete();
    cyc(10);
    chk("wrap_f0",   {32'd0, fetched[0]}, 64'hFFFFFFFC);
    chk("wrap_f1",   {32'd0, fetched[1]}, 64'h0);
    chk("wrap_pc",   {32'd0, bus.pc_out}, 64'hFFFFFFFC);

    redirect(32'h103, 1'b0);
    fetched.delete();
    cyc(6);
    chk("algn_f0",   {32'd0, fetched[0]}, 64'h100);

    redirect(32'h20, 1'b0);
    fetched.delete();
    cyc(10);
    chk("br_f0",     {32'd0, fetched[0]}, 64'h20);
    chk("br_inst",   {32'd0, bus.inst}, 64'hFE000EE3);
    chk("br_pc",     {32'd0, bus.pc_out}, 64'h20);
`ifdef IF_BTFN_EN
    chk("br_f1",     {32'd0, fetched[1]}, 64'h1C);
    chk("br_pred",   {63'd0, bus.pred_taken}, 64'd1);
`else
    chk("br_f1",     {32'd0, fetched[1]}, 64'h24);
    chk("br_pred",   {63'd0, bus.pred_taken}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
